// File: rtl/mult_iter_param.sv
// rtl/mult_iter_param.sv - parametrised iterative signed/unsigned N-bit multiplier
//
// One CHUNK x CHUNK partial product is accumulated per cycle, followed by a
// single sign-fix cycle, so latency is (WIDTH/CHUNK)^2 + 1 cycles in either mode.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request, sampled only while idle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b         WIDTH-bit operands (sampled with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product becomes valid
//   product      2*WIDTH-bit result, held until the next accepted start
module mult_iter_param #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic               neg;
  // idx is kept as its (i, j) digits so no divider/modulo is needed.
  logic [CW-1:0]      i_idx;
  logic [CW-1:0]      j_idx;

  logic [WIDTH-1:0]   ma_sh;
  logic [WIDTH-1:0]   mb_sh;
  logic [2*CHUNK-1:0] pp;
  logic [2*WIDTH-1:0] pp_ext;

  always_comb begin
    ma_sh  = ma >> (CHUNK * int'(i_idx));
    mb_sh  = mb >> (CHUNK * int'(j_idx));
    pp     = {{CHUNK{1'b0}}, ma_sh[CHUNK-1:0]} * {{CHUNK{1'b0}}, mb_sh[CHUNK-1:0]};
    pp_ext = '0;
    pp_ext[2*CHUNK-1:0] = pp;
    pp_ext = pp_ext << (CHUNK * (int'(i_idx) + int'(j_idx)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ma      <= '0;
      mb      <= '0;
      neg     <= 1'b0;
      i_idx   <= '0;
      j_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
            ma      <= (signed_mode && a[WIDTH-1]) ? -a : a;
            mb      <= (signed_mode && b[WIDTH-1]) ? -b : b;
            neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            product <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          product <= product + pp_ext;
          if (i_idx == LAST) begin
            i_idx <= '0;
            if (j_idx == LAST) begin
              j_idx <= '0;
              state <= FIX;
            end else begin
              j_idx <= j_idx + CW'(1);
            end
          end else begin
            i_idx <= i_idx + CW'(1);
          end
        end
        FIX: begin
          if (neg) begin
            product <= -product;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
